spike_tdoa_decoder_3ch: RTL and testbench

Receive-side decoder for the 3-channel pressure-sensor spike field. It watches the three delayed spike lines over a fixed measurement window and records, per channel, a saturating spike count (rate/density estimate) and the first-arrival timestamp (time-of-flight estimate). At window end it reports the densest channel and the earliest-arriving channel, which feed downstream source localisation.

---
 rtl/spike_tdoa_decoder_3ch_pkg.sv | 13 +
 rtl/spike_tdoa_decoder_3ch_if.sv | 29 ++
 rtl/spike_tdoa_decoder_3ch_chan_acc.sv | 43 ++++
 rtl/spike_tdoa_decoder_3ch.sv | 164 ++++++++++++++++
 tb/tb_spike_tdoa_decoder_3ch.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spike_tdoa_decoder_3ch_pkg.sv
// Shared types and constants for the 3-channel spike TDOA decoder.
package spike_decode_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPORT  = 2'd2
    } dec_state_e;

    localparam int unsigned NCH   = 3;
    localparam logic [1:0]  NO_CH = 2'd3;

endpackage

// File: rtl/spike_tdoa_decoder_3ch_if.sv
// Control, spike and result signals of the spike TDOA decoder.
interface spike_tdoa_decoder_3ch_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TS_W  = 10
);
    import spike_decode_pkg::*;

    logic                 clk_en;
    logic                 start_i;
    logic [NCH-1:0]       spike_i;
    logic                 busy_o;
    logic                 valid_o;
    logic [CNT_W-1:0]     count_o    [NCH];
    logic [TS_W-1:0]      first_ts_o [NCH];
    logic [NCH-1:0]       seen_o;
    logic [1:0]           dense_ch_o;
    logic [1:0]           first_ch_o;

    modport master (
        output clk_en, start_i, spike_i,
        input  busy_o, valid_o, count_o, first_ts_o, seen_o, dense_ch_o, first_ch_o
    );

    modport slave (
        input  clk_en, start_i, spike_i,
        output busy_o, valid_o, count_o, first_ts_o, seen_o, dense_ch_o, first_ch_o
    );

endinterface

// File: rtl/spike_tdoa_decoder_3ch_chan_acc.sv
// Per-channel accumulator: saturating spike count plus first-arrival timestamp capture.
module spike_chan_acc
    import spike_decode_pkg::*;
#(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TS_W  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_collect,
    input  logic             i_spike,
    input  logic [TS_W-1:0]  i_timer,
    output logic [CNT_W-1:0] o_count,
    output logic [TS_W-1:0]  o_ts,
    output logic             o_seen
);

    logic [CNT_W-1:0] r_count;
    logic [TS_W-1:0]  r_ts;
    logic             r_seen;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_count <= '0;
            r_ts    <= '1;
            r_seen  <= 1'b0;
        end else if (i_collect && i_spike) begin
            if (r_count != '1) begin
                r_count <= r_count + 1'b1;
            end
            if (!r_seen) begin
                r_ts   <= i_timer;
                r_seen <= 1'b1;
            end
        end
    end

    assign o_count = r_count;
    assign o_ts    = r_ts;
    assign o_seen  = r_seen;

endmodule

// File: rtl/spike_tdoa_decoder_3ch.sv
// Windowed 3-channel spike decoder: per-channel counts and first arrivals,
// reporting the densest and earliest channels at window end.
module spike_tdoa_decoder_3ch
    import spike_decode_pkg::*;
#(
    parameter int unsigned WIN_CYCLES = 1024,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned TS_W       = $clog2(WIN_CYCLES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    spike_tdoa_decoder_3ch_if.slave bus
);

    localparam logic [TS_W-1:0] LAST_TS = TS_W'(WIN_CYCLES - 1);

    dec_state_e       r_state;
    dec_state_e       w_next;
    logic             w_clear;
    logic             w_collect;
    logic             w_report;
    logic             w_last;
    logic [TS_W-1:0]  r_timer;

    logic [CNT_W-1:0] w_acc_count [NCH];
    logic [TS_W-1:0]  w_acc_ts    [NCH];
    logic [NCH-1:0]   w_acc_seen;

    logic [1:0]       w_dense;
    logic [1:0]       w_first;
    logic [CNT_W-1:0] w_max;
    logic [TS_W-1:0]  w_min;
    logic             w_any;

    logic             r_valid;
    logic [CNT_W-1:0] r_count_o [NCH];
    logic [TS_W-1:0]  r_ts_o    [NCH];
    logic [NCH-1:0]   r_seen_o;
    logic [1:0]       r_dense;
    logic [1:0]       r_first;

    assign w_last = (r_timer == LAST_TS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_clear   = 1'b0;
        w_collect = 1'b0;
        w_report  = 1'b0;
        if (bus.clk_en) begin
            case (r_state)
                IDLE: begin
                    if (bus.start_i) begin
                        w_clear = 1'b1;
                        w_next  = COLLECT;
                    end
                end
                COLLECT: begin
                    w_collect = 1'b1;
                    if (w_last) begin
                        w_next = REPORT;
                    end
                end
                REPORT: begin
                    w_report = 1'b1;
                    w_next   = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Timer holds at the last value instead of wrapping; the FSM leaves COLLECT there.
    always_ff @(posedge clk) begin
        if (!rst_n || w_clear) begin
            r_timer <= '0;
        end else if (w_collect && !w_last) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        spike_chan_acc #(
            .CNT_W (CNT_W),
            .TS_W  (TS_W)
        ) u_acc (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_clear   (w_clear),
            .i_collect (w_collect),
            .i_spike   (bus.spike_i[k]),
            .i_timer   (r_timer),
            .o_count   (w_acc_count[k]),
            .o_ts      (w_acc_ts[k]),
            .o_seen    (w_acc_seen[k])
        );
    end

    // Strict comparisons keep the lowest index on ties.
    always_comb begin
        w_dense = NO_CH;
        w_max   = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (w_acc_count[k] > w_max) begin
                w_max   = w_acc_count[k];
                w_dense = 2'(k);
            end
        end
    end

    // Seen flags gate the search so a genuine all-ones timestamp still qualifies.
    always_comb begin
        w_first = NO_CH;
        w_min   = '1;
        w_any   = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (w_acc_seen[k] && (!w_any || (w_acc_ts[k] < w_min))) begin
                w_any   = 1'b1;
                w_min   = w_acc_ts[k];
                w_first = 2'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_seen_o <= '0;
            r_dense  <= NO_CH;
            r_first  <= NO_CH;
            for (int unsigned k = 0; k < NCH; k++) begin
                r_count_o[k] <= '0;
                r_ts_o[k]    <= '1;
            end
        end else begin
            r_valid <= w_report;
            if (w_report) begin
                r_seen_o <= w_acc_seen;
                r_dense  <= w_dense;
                r_first  <= w_first;
                for (int unsigned k = 0; k < NCH; k++) begin
                    r_count_o[k] <= w_acc_count[k];
                    r_ts_o[k]    <= w_acc_seen[k] ? w_acc_ts[k] : '1;
                end
            end
        end
    end

    assign bus.busy_o     = (r_state != IDLE);
    assign bus.valid_o    = r_valid;
    assign bus.count_o    = r_count_o;
    assign bus.first_ts_o = r_ts_o;
    assign bus.seen_o     = r_seen_o;
    assign bus.dense_ch_o = r_dense;
    assign bus.first_ch_o = r_first;

endmodule

// File: tb/tb_spike_tdoa_decoder_3ch.sv
// Self-checking bench for spike_tdoa_decoder_3ch: table vectors, control hazards
// and randomized windows against a reference model.
module tb_spike_tdoa_decoder_3ch;
    import spike_decode_pkg::*;

    localparam int WIN = 16;
    localparam int CW  = 4;
    localparam int TW  = 4;

    typedef struct {
        string           name;
        logic [2:0][15:0] m;
        logic [2:0][3:0]  cnt;
        logic [2:0][3:0]  ts;
        logic [2:0]       seen;
        logic [1:0]       dn;
        logic [1:0]       fc;
        int               p;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spike_tdoa_decoder_3ch_if #(.CNT_W(CW), .TS_W(TW)) bus ();

    spike_tdoa_decoder_3ch #(
        .WIN_CYCLES (WIN),
        .CNT_W      (CW),
        .TS_W       (TW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors  = 0;
    int checks  = 0;
    int edges   = 0;
    int vcnt    = 0;
    int first_v = -1;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clk_cycle(input logic en, input logic [2:0] spk, input logic st);
        bus.clk_en  = en;
        bus.spike_i = spk;
        bus.start_i = st;
        @(posedge clk);
        #1;
        edges++;
        if (bus.valid_o) begin
            vcnt++;
            if (first_v < 0) first_v = edges;
        end
    endtask

    task automatic step(input int p, input logic [2:0] spk, input logic st);
        for (int i = 0; i < p - 1; i++) clk_cycle(1'b0, 3'($urandom), 1'($urandom));
        clk_cycle(1'b1, spk, st);
    endtask

    task automatic check_outputs(input string tag, input logic [2:0][3:0] cnt,
                                 input logic [2:0][3:0] ts, input logic [2:0] seen,
                                 input logic [1:0] dn, input logic [1:0] fc);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s count%0d", tag, k), 32'(bus.count_o[k]), 32'(cnt[k]));
            chk($sformatf("%s ts%0d", tag, k), 32'(bus.first_ts_o[k]), 32'(ts[k]));
        end
        chk({tag, " seen"}, 32'(bus.seen_o), 32'(seen));
        chk({tag, " dense"}, 32'(bus.dense_ch_o), 32'(dn));
        chk({tag, " first"}, 32'(bus.first_ch_o), 32'(fc));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " valid"}, 32'(bus.valid_o), 32'd0);
        chk({tag, " busy"}, 32'(bus.busy_o), 32'd0);
        check_outputs(tag, '0, {4'd15, 4'd15, 4'd15}, 3'b000, NO_CH, NO_CH);
    endtask

    // restart: timer index at which start_i is re-pulsed, 99 = held high throughout
    task automatic run_window(input string tag, input logic [2:0][15:0] m, input int p,
                              input int restart, input logic [2:0][3:0] cnt,
                              input logic [2:0][3:0] ts, input logic [2:0] seen,
                              input logic [1:0] dn, input logic [1:0] fc);
        int e0;
        int v0;
        v0 = vcnt;
        first_v = -1;
        step(p, 3'($urandom), 1'b1);
        e0 = edges;
        chk({tag, " busy_start"}, 32'(bus.busy_o), 32'd1);
        for (int t = 0; t < WIN; t++) begin
            step(p, {m[2][t], m[1][t], m[0][t]}, (restart == t) || (restart == 99));
            if (t == 8) chk({tag, " busy_mid"}, 32'(bus.busy_o), 32'd1);
        end
        chk({tag, " no_early_valid"}, 32'(vcnt - v0), 32'd0);
        step(p, 3'($urandom), restart == 99);
        chk({tag, " latency"}, 32'(first_v - e0), 32'((WIN + 1) * p));
        chk({tag, " busy_end"}, 32'(bus.busy_o), 32'd0);
        check_outputs(tag, cnt, ts, seen, dn, fc);
        clk_cycle(1'b0, 3'($urandom), 1'b0);
        chk({tag, " valid_width"}, 32'(bus.valid_o), 32'd0);
        chk({tag, " valid_count"}, 32'(vcnt - v0), 32'd1);
    endtask

    function automatic void model(input logic [2:0][15:0] m, output logic [2:0][3:0] cnt,
                                  output logic [2:0][3:0] ts, output logic [2:0] seen,
                                  output logic [1:0] dn, output logic [1:0] fc);
        int best;
        int bt;
        for (int k = 0; k < 3; k++) begin
            int n;
            n = $countones(m[k]);
            cnt[k]  = 4'((n > 15) ? 15 : n);
            seen[k] = |m[k];
            ts[k]   = 4'd15;
            for (int t = 15; t >= 0; t--) if (m[k][t]) ts[k] = 4'(t);
        end
        dn = 2'd3;
        best = 0;
        for (int k = 0; k < 3; k++) if (int'(cnt[k]) > best) begin best = int'(cnt[k]); dn = 2'(k); end
        fc = 2'd3;
        bt = 16;
        for (int k = 0; k < 3; k++) if (seen[k] && int'(ts[k]) < bt) begin bt = int'(ts[k]); fc = 2'(k); end
    endfunction

    function automatic vec_t mk(string n, logic [15:0] m0, logic [15:0] m1, logic [15:0] m2,
                                logic [3:0] c0, logic [3:0] c1, logic [3:0] c2,
                                logic [3:0] t0, logic [3:0] t1, logic [3:0] t2,
                                logic [2:0] s, logic [1:0] d, logic [1:0] f, int p);
        vec_t v;
        v.name = n;
        v.m    = {m2, m1, m0};
        v.cnt  = {c2, c1, c0};
        v.ts   = {t2, t1, t0};
        v.seen = s;
        v.dn   = d;
        v.fc   = f;
        v.p    = p;
        return v;
    endfunction

    function automatic logic [15:0] rand_mask();
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return 16'($urandom & $urandom & $urandom);
            2:       return 16'($urandom | $urandom);
            default: return 16'h0001 << $urandom_range(0, 15);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0][15:0] m;
        logic [2:0][3:0]  cnt;
        logic [2:0][3:0]  ts;
        logic [2:0]       seen;
        logic [1:0]       dn;
        logic [1:0]       fc;
        int               v0;

        vecs[0] = mk("basic",  16'h0008, 16'h0222, 16'h0000, 1, 3, 0, 3, 1, 15, 3'b011, 2'd1, 2'd1, 1);
        vecs[1] = mk("sat",    16'h8000, 16'h0000, 16'hFFFF, 1, 0, 15, 15, 15, 0, 3'b101, 2'd2, 2'd2, 1);
        vecs[2] = mk("tie",    16'h0110, 16'h0000, 16'h0110, 2, 0, 2, 4, 15, 4, 3'b101, 2'd0, 2'd0, 1);
        vecs[3] = mk("gated",  16'h0008, 16'h0222, 16'h0000, 1, 3, 0, 3, 1, 15, 3'b011, 2'd1, 2'd1, 3);
        vecs[4] = mk("silent", 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 15, 15, 15, 3'b000, 2'd3, 2'd3, 1);
        vecs[5] = mk("last",   16'h0000, 16'h8000, 16'h0000, 0, 1, 0, 15, 15, 15, 3'b010, 2'd1, 2'd1, 1);
        vecs[6] = mk("split",  16'h0C00, 16'h000C, 16'h0001, 2, 2, 1, 10, 2, 0, 3'b111, 2'd0, 2'd2, 2);

        bus.clk_en  = 1'b0;
        bus.start_i = 1'b0;
        bus.spike_i = '0;

        // Reset with start and spikes present, then idle spiking without start
        rst_n = 1'b0;
        clk_cycle(1'b1, 3'b111, 1'b1);
        clk_cycle(1'b0, 3'b111, 1'b1);
        rst_n = 1'b1;
        check_reset_outputs("reset");
        for (int i = 0; i < 12; i++) clk_cycle(1'b1, 3'($urandom), 1'b0);
        chk("idle no_valid", 32'(vcnt), 32'd0);
        check_reset_outputs("idle");

        foreach (vecs[i]) begin
            run_window(vecs[i].name, vecs[i].m, vecs[i].p, -1, vecs[i].cnt, vecs[i].ts,
                       vecs[i].seen, vecs[i].dn, vecs[i].fc);
        end

        // Start re-pulsed mid-window must not disturb the result
        run_window("restart7", vecs[0].m, 1, 7, vecs[0].cnt, vecs[0].ts,
                   vecs[0].seen, vecs[0].dn, vecs[0].fc);

        // Reset at timer 10 aborts the window
        v0 = vcnt;
        step(1, 3'b000, 1'b1);
        for (int t = 0; t < 10; t++) step(1, {vecs[2].m[2][t], vecs[2].m[1][t], vecs[2].m[0][t]}, 1'b0);
        rst_n = 1'b0;
        clk_cycle(1'b1, 3'b111, 1'b0);
        rst_n = 1'b1;
        check_reset_outputs("abort");
        for (int i = 0; i < 24; i++) clk_cycle(1'b1, 3'($urandom), 1'b0);
        chk("abort no_valid", 32'(vcnt - v0), 32'd0);
        chk("abort busy", 32'(bus.busy_o), 32'd0);
        run_window("after_abort", vecs[2].m, 1, -1, vecs[2].cnt, vecs[2].ts,
                   vecs[2].seen, vecs[2].dn, vecs[2].fc);

        // Back-to-back windows with start held high, randomized content
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 3; k++) m[k] = rand_mask();
            model(m, cnt, ts, seen, dn, fc);
            run_window($sformatf("b2b%0d", w), m, 1, 99, cnt, ts, seen, dn, fc);
        end

        for (int w = 0; w < 10; w++) begin
            int p;
            int rs;
            for (int k = 0; k < 3; k++) m[k] = rand_mask();
            p  = $urandom_range(1, 3);
            rs = $urandom_range(0, 24);
            model(m, cnt, ts, seen, dn, fc);
            run_window($sformatf("rand%0d", w), m, p, rs, cnt, ts, seen, dn, fc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
